// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with per-channel strobes.
// Reconfiguring any channel resyncs all channels and re-runs the lock settle.
module clk_div_gen #(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = 16,
    parameter  int DIV_INIT    = 4,
    parameter  int LOCK_CYCLES = 16,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outclk_en,
    output logic              locked
);

    localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_INIT);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DIV_INIT / 2);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SET_W-1:0] settle_q;
    logic [SET_W-1:0] settle_d;
    logic             accept;

    logic [CNT_W-1:0] div_q   [NUM_CH];
    logic [CNT_W-1:0] high_q  [NUM_CH];
    logic [CNT_W-1:0] phase_q [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];

    logic [CNT_W-1:0] div_d   [NUM_CH];
    logic [CNT_W-1:0] high_d  [NUM_CH];
    logic [CNT_W-1:0] phase_d [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];

    logic [NUM_CH-1:0] clk_d;
    logic [NUM_CH-1:0] stb_d;
    logic [CNT_W-1:0]  phase_clamp;

    // FSM: settle counter, then hold LOCKED until a config is accepted
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        cfg_ready = (state_q == LOCKED);
        accept    = cfg_valid && (state_q == LOCKED);
        unique case (state_q)
            SETTLE: begin
                settle_d = settle_q + SET_W'(1);
                if (settle_q == SET_LAST) begin
                    state_d  = LOCKED;
                    settle_d = '0;
                end
            end
            LOCKED: begin
                if (accept) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            default: begin
                state_d  = SETTLE;
                settle_d = '0;
            end
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            locked   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            locked   <= (state_q == LOCKED);
        end
    end

    assign phase_clamp = (cfg_phase >= cfg_div) ? cfg_div - ONE : cfg_phase;

    // Channel datapath; an accept reloads every enabled counter with its phase
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_d[i]   = div_q[i];
            high_d[i]  = high_q[i];
            phase_d[i] = phase_q[i];
            if (accept && (cfg_ch == CH_W'(i))) begin
                div_d[i]   = cfg_div;
                high_d[i]  = cfg_high;
                phase_d[i] = phase_clamp;
            end

            if (div_d[i] < TWO) begin
                cnt_d[i] = '0;
            end else if (accept) begin
                cnt_d[i] = phase_d[i];
            end else if (cnt_q[i] >= div_q[i] - ONE) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end

            clk_d[i] = (div_q[i] >= TWO) && (cnt_q[i] < high_q[i]);
            stb_d[i] = (div_q[i] >= TWO) && (cnt_q[i] == '0);
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            outclk    <= '0;
            outclk_en <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= DIV_RST;
                high_q[i]  <= HIGH_RST;
                phase_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            outclk    <= clk_d;
            outclk_en <= stb_d;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= div_d[i];
                high_q[i]  <= high_d[i];
                phase_q[i] <= phase_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

endmodule
